// File: rtl/mips_pkg.sv
// Shared pipeline definitions: default widths and the fetch-queue entry layout.
package mips_pkg;

    localparam int FQ_DATA_W = 32;
    localparam int FQ_DEPTH  = 4;

    typedef struct packed {
        logic [FQ_DATA_W-1:0] pc;
        logic [FQ_DATA_W-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Fetch-queue storage: DEPTH x WIDTH register array, synchronous write, combinational read.
module fetch_queue_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage is deliberately not reset; entry validity lives in the parent's count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between IF and ID: circular FIFO of {pc, instr} with flush.
module fetch_queue
    import mips_pkg::*;
#(
    parameter int DEPTH  = FQ_DEPTH,
    parameter int DATA_W = FQ_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     if_valid,
    input  logic [DATA_W-1:0]        if_pc,
    input  logic [DATA_W-1:0]        if_instr,
    output logic                     if_stall,
    input  logic                     flush,
    input  logic                     id_ready,
    output logic                     id_valid,
    output logic [DATA_W-1:0]        id_pc,
    output logic [DATA_W-1:0]        id_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [CW-1:0]       count_q;
    logic                full;
    logic                push;
    logic                pop;
    logic [2*DATA_W-1:0] rd_data;

    // Full blocks pushes outright, even when a pop frees a slot in the same cycle.
    assign full     = (count_q == CW'(DEPTH));
    assign push     = if_valid && !full && !flush;
    assign pop      = id_valid && id_ready && !flush;

    assign if_stall = full;
    assign id_valid = (count_q != '0);
    assign id_pc    = id_valid ? rd_data[2*DATA_W-1:DATA_W] : '0;
    assign id_instr = id_valid ? rd_data[DATA_W-1:0]        : '0;
    assign count    = count_q;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            // Pointers are AW bits wide, so DEPTH being a power of two gives the wrap for free.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (2*DATA_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push),
        .wr_addr (wr_ptr),
        .wr_data ({if_pc, if_instr}),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic against a queue model.
module tb_fetch_queue;
    import mips_pkg::*;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   if_valid = 1'b0;
    logic [DATA_W-1:0]      if_pc = '0;
    logic [DATA_W-1:0]      if_instr = '0;
    logic                   if_stall;
    logic                   flush = 1'b0;
    logic                   id_ready = 1'b0;
    logic                   id_valid;
    logic [DATA_W-1:0]      id_pc;
    logic [DATA_W-1:0]      id_instr;
    logic [$clog2(DEPTH):0] count;

    int tests_run = 0;
    int tests_failed = 0;

    fq_entry_t model_q[$];

    fetch_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .if_valid (if_valid),
        .if_pc    (if_pc),
        .if_instr (if_instr),
        .if_stall (if_stall),
        .flush    (flush),
        .id_ready (id_ready),
        .id_valid (id_valid),
        .id_pc    (id_pc),
        .id_instr (id_instr),
        .count    (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare every output against what the model's current contents imply.
    task automatic check_outputs(input string tag);
        int n;
        n = model_q.size();
        check({tag, "_count"}, 64'(count), 64'(n));
        check({tag, "_id_valid"}, 64'(id_valid), 64'(n != 0));
        check({tag, "_if_stall"}, 64'(if_stall), 64'(n == DEPTH));
        check({tag, "_id_pc"}, 64'(id_pc), (n == 0) ? 64'd0 : 64'(model_q[0].pc));
        check({tag, "_id_instr"}, 64'(id_instr), (n == 0) ? 64'd0 : 64'(model_q[0].instr));
    endtask

    // One clock: drive inputs, check pre-edge outputs, take the edge, update the model.
    task automatic cycle(input logic v, input logic [DATA_W-1:0] pc, input logic [DATA_W-1:0] instr,
                         input logic fl, input logic rdy, input string tag);
        int n;
        fq_entry_t e;
        if_valid = v;
        if_pc    = pc;
        if_instr = instr;
        flush    = fl;
        id_ready = rdy;
        #1;
        check_outputs(tag);
        @(posedge clk);
        n = model_q.size();
        if (fl) begin
            model_q.delete();
        end else begin
            if (rdy && n > 0) void'(model_q.pop_front());
            if (v && n < DEPTH) begin
                e.pc    = pc;
                e.instr = instr;
                model_q.push_back(e);
            end
        end
        @(negedge clk);
        if_valid = 1'b0;
        flush    = 1'b0;
        id_ready = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Single push shows at head one cycle later
        cycle(1'b1, 32'h0, 32'h2008_0005, 1'b0, 1'b0, "push1");
        check("push1_valid", 64'(id_valid), 64'd1);
        check("push1_pc", 64'(id_pc), 64'h0);
        check("push1_instr", 64'(id_instr), 64'h2008_0005);
        check("push1_count", 64'(count), 64'd1);
        cycle(1'b0, '0, '0, 1'b1, 1'b0, "flush_a");

        // Fill to full, dropped fifth push, ordered drain
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'(i * 4), 32'hA000_0000 + 32'(i), 1'b0, 1'b0, "fill");
        check("full_count", 64'(count), 64'd4);
        check("full_stall", 64'(if_stall), 64'd1);
        cycle(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, "drop");
        check("drop_count", 64'(count), 64'd4);
        cycle(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b1, "full_pop_push");
        check("no_pushthru_count", 64'(count), 64'd3);
        for (int i = 1; i < 4; i++) begin
            check("drain_order", 64'(id_pc), 64'(i * 4));
            cycle(1'b0, '0, '0, 1'b0, 1'b1, "drain");
        end
        check("drained_valid", 64'(id_valid), 64'd0);

        // Steady push+pop at count 2 across the pointer wrap
        cycle(1'b0, '0, '0, 1'b1, 1'b0, "flush_b");
        cycle(1'b1, 32'h100, 32'h1, 1'b0, 1'b0, "pp_pre");
        cycle(1'b1, 32'h104, 32'h2, 1'b0, 1'b0, "pp_pre");
        for (int i = 0; i < 6; i++) begin
            check("pp_head", 64'(id_pc), 64'(32'h100 + 32'(i * 4)));
            cycle(1'b1, 32'h108 + 32'(i * 4), 32'(i + 3), 1'b0, 1'b1, "pp");
            check("pp_count", 64'(count), 64'd2);
        end

        // Flush wins over same-cycle push and pop
        cycle(1'b1, 32'h200, 32'h7, 1'b0, 1'b0, "pre_flush");
        check("pre_flush_count", 64'(count), 64'd3);
        cycle(1'b1, 32'h204, 32'h8, 1'b1, 1'b1, "flush_c");
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid", 64'(id_valid), 64'd0);
        check("flush_pc", 64'(id_pc), 64'd0);
        check("flush_stall", 64'(if_stall), 64'd0);

        // Pop attempts while empty
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, '0, 1'b0, 1'b1, "empty_pop");
        check("empty_count", 64'(count), 64'd0);
        cycle(1'b1, 32'h300, 32'h9, 1'b0, 1'b0, "after_empty");
        check("after_empty_pc", 64'(id_pc), 64'h300);

        // Asynchronous reset between edges
        cycle(1'b1, 32'h304, 32'hA, 1'b0, 1'b0, "pre_rst");
        check("pre_rst_count", 64'(count), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        model_q.delete();
        check("async_rst_valid", 64'(id_valid), 64'd0);
        check("async_rst_count", 64'(count), 64'd0);
        check_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 32'h400, 32'hB, 1'b0, 1'b0, "post_rst");
        check("post_rst_pc", 64'(id_pc), 64'h400);
        check("post_rst_instr", 64'(id_instr), 64'hB);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(3) != 0), $urandom, $urandom,
                  ($urandom_range(31) == 0), $urandom_range(1) == 1, "rand");
        end
        #1;
        check_outputs("final");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter: DEPTH, default 4, number of entries (power of 2, >= 2).
REQ-002 SHALL have parameter: DATA_W, default 32, width of PC and instruction fields.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: if_valid  input  1  fetch presents an entry this cycle.
REQ-006 SHALL have port: if_pc  input  DATA_W  PC of fetched instruction.
REQ-007 SHALL have port: if_instr  input  DATA_W  fetched instruction word.
REQ-008 SHALL have port: if_stall  output  1  queue full; fetch holds PC (drives PC-register stall).
REQ-009 SHALL have port: flush  input  1  redirect (jump/branch taken); discard all entries.
REQ-010 SHALL have port: id_ready  input  1  decode accepts head entry this cycle.
REQ-011 SHALL have port: id_valid  output  1  head entry present.
REQ-012 SHALL have port: id_pc  output  DATA_W  PC of head entry.
REQ-013 SHALL have port: id_instr  output  DATA_W  instruction of head entry.
REQ-014 SHALL have port: count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-015 SHALL implement a circular FIFO of DEPTH {pc, instr} entries with write pointer, read pointer, occupancy counter.
REQ-016 SHALL accept a push when if_valid=1, count<DEPTH, flush=0: store at wr_ptr, wr_ptr+1 mod DEPTH.
REQ-017 SHALL perform a pop when id_valid=1, id_ready=1, flush=0: rd_ptr+1 mod DEPTH.
REQ-018 SHALL keep count unchanged on simultaneous push and pop; +1 push only; -1 pop only.
REQ-019 SHALL drive if_stall=1 combinationally iff count==DEPTH; no push-through when full, even with same-cycle pop.
REQ-020 SHALL ignore if_valid while full; entry not stored, no state change from it.
REQ-021 SHALL drive id_valid=1 iff count!=0; no bypass: push-to-id_valid latency is exactly 1 cycle.
REQ-022 SHALL drive id_pc/id_instr from the entry at rd_ptr when id_valid=1, and 0 when id_valid=0.
REQ-023 SHALL ignore id_ready while empty; count never underflows.
REQ-024 SHALL on flush=1 set wr_ptr=rd_ptr=0, count=0 at next edge, overriding any same-cycle push or pop.
REQ-025 SHALL hold head entry and outputs stable while id_valid=1 and id_ready=0.
REQ-026 SHALL wrap pointers modulo DEPTH with no lost or duplicated entries across wrap.

Reset
REQ-027 SHALL on rst_n=0 immediately clear wr_ptr, rd_ptr, count to 0, giving id_valid=0, if_stall=0, id_pc=0, id_instr=0, count=0.
REQ-028 SHALL discard all entries on reset asserted mid-operation; storage array need not be reset.
REQ-029 SHALL resume normal push/pop on first rising edge after rst_n deasserts.

Structure
REQ-030 SHALL place DATA_W default, DEPTH default, and fq_entry_t typedef {pc, instr} in shared package mips_pkg.
REQ-031 SHALL instantiate one sub-module fetch_queue_mem: DEPTH x (2*DATA_W) register array, synchronous write, combinational read.
REQ-032 SHALL keep pointer/count control in fetch_queue; fetch_queue_mem holds no control logic.

Verification
REQ-033 SHALL cover: reset, push pc=0x0/instr=0x20080005 -> next cycle id_valid=1, id_pc=0x0, id_instr=0x20080005, count=1.
REQ-034 SHALL cover: 4 pushes pc=0x0,0x4,0x8,0xC with id_ready=0 -> count=4, if_stall=1; 5th push pc=0x10 dropped; pops return 0x0,0x4,0x8,0xC in order.
REQ-035 SHALL cover: count=2, simultaneous push and pop -> count stays 2, head advances; 6 push/pop cycles cross wrap with order preserved.
REQ-036 SHALL cover: count=3, flush=1 with if_valid=1 and id_ready=1 same cycle -> next cycle count=0, id_valid=0, id_pc=0, if_stall=0.
REQ-037 SHALL cover: empty with id_ready=1 for 3 cycles -> count stays 0, id_valid=0, no pointer change.
REQ-038 SHALL cover: count=2, rst_n low between edges -> id_valid=0, count=0 immediately without clock; first post-reset push appears at head.
